// File: rtl/alu_share_sequencer.sv
// Shares one multi-cycle ALU between two requesters: round-robin grant, operand issue, fixed-latency wait, result return.
// Optional per-requester completed-operation counters are enabled by defining ALU_SEQ_CNT_EN.
module alu_share_sequencer #(
    parameter int WIDTH       = 8,
    parameter int OPW         = 3,
    parameter int ALU_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_b,
    output logic             alu_start,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
`ifdef ALU_SEQ_CNT_EN
    output logic [7:0]       op_cnt0,
    output logic [7:0]       op_cnt1,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, EXEC, RESP} state_t;

    state_t     state, state_nxt;
    logic       last_grant;
    logic       cur;
    logic       grant;
    logic       accept;
    logic       capture;
    logic       rsp_done;
    logic [3:0] cnt;

    // A tie goes to whoever did not win last time; otherwise the single valid requester wins.
    assign grant    = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    assign accept   = (state == IDLE) && (req_valid != 2'b00);
    assign capture  = ((state == ISSUE) && (ALU_LATENCY == 0)) ||
                      ((state == EXEC) && (cnt == 4'd1));
    assign rsp_done = (state == RESP) && rsp_ready[cur];

    // NOTE: reset is sampled on the clock edge, so it lives inside the clocked block, not its sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: the default assignment first keeps this combinational block from inferring a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (accept) state_nxt = ISSUE;
            ISSUE: state_nxt = (ALU_LATENCY == 0) ? RESP : EXEC;
            EXEC:  if (capture) state_nxt = RESP;
            RESP:  if (rsp_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        alu_start = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE:    if (req_valid != 2'b00) req_ready = grant ? 2'b10 : 2'b01;
            ISSUE:   alu_start = 1'b1;
            RESP:    rsp_valid = cur ? 2'b10 : 2'b01;
            default: ;
        endcase
    end

    // NOTE: sequential state always uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_data   <= '0;
            cur        <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
        end else begin
            if (accept) begin
                alu_op     <= grant ? req1_op : req0_op;
                alu_a      <= grant ? req1_a  : req0_a;
                alu_b      <= grant ? req1_b  : req0_b;
                cur        <= grant;
                last_grant <= grant;
            end
            if (state == ISSUE)     cnt <= 4'(ALU_LATENCY);
            else if (state == EXEC) cnt <= cnt - 4'd1;
            if (capture) rsp_data <= alu_result;
        end
    end

`ifdef ALU_SEQ_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_cnt0 <= '0;
            op_cnt1 <= '0;
        end else if (rsp_done) begin
            if (!cur && op_cnt0 != 8'hFF) op_cnt0 <= op_cnt0 + 8'd1;
            if (cur  && op_cnt1 != 8'hFF) op_cnt1 <= op_cnt1 + 8'd1;
        end
    end
`endif

endmodule
